// File: rtl/calc_pkg.sv
// Shared definitions for the BCD calculator controller: key codes, ALU opcodes
// and the controller state type.
package calc_pkg;

  localparam logic [4:0] KEY_ADD = 5'd10;
  localparam logic [4:0] KEY_SUB = 5'd11;
  localparam logic [4:0] KEY_EQ  = 5'd12;
  localparam logic [4:0] KEY_CLR = 5'd13;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b010;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_EXEC,
    ST_NEG,
    ST_SHOW
  } calc_state_t;

  function automatic logic is_digit(input logic [4:0] code);
    return code <= 5'd9;
  endfunction

  function automatic logic is_operator(input logic [4:0] code);
    return (code == KEY_ADD) || (code == KEY_SUB);
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Two-digit packed-BCD entry register: clear beats load beats digit shift.
module bcd_entry_reg
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       shift,
  input  logic [3:0] digit,
  output logic [7:0] value
);

  // New digits enter the low nibble; the oldest digit falls off the top.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      value <= 8'h00;
    end else if (clear) begin
      value <= 8'h00;
    end else if (load) begin
      value <= load_val;
    end else if (shift) begin
      value <= {value[3:0], digit};
    end
  end

endmodule

// File: rtl/bcd_calc_ctrl.sv
// Sequencing controller for the shared 2-digit BCD add/subtract ALU.
// Define CALC_CHAIN_EN to let an operator in SHOW chain the result into A.
module bcd_calc_ctrl
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic       key_ready,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  output logic [7:0] display,
  output logic       neg,
  output logic       ovf,
  output logic       result_valid,
  output logic       busy
);

  calc_state_t state, state_nxt;

  logic [7:0] a_val, b_val, result_q, a_load_val;
  logic [2:0] op_q;
  logic       accept;
  logic       a_clr, a_load, a_shift, b_clr, b_shift;
  logic       op_load, cap_exec, cap_neg, flags_clr, ovf_clr, rv_set;

  assign accept    = key_valid && key_ready;
  assign key_ready = (state != ST_EXEC) && (state != ST_NEG);
  assign busy      = !key_ready;

  bcd_entry_reg u_reg_a (
    .clk      (clk),
    .nrst     (nrst),
    .clear    (a_clr),
    .load     (a_load),
    .load_val (a_load_val),
    .shift    (a_shift),
    .digit    (key_code[3:0]),
    .value    (a_val)
  );

  bcd_entry_reg u_reg_b (
    .clk      (clk),
    .nrst     (nrst),
    .clear    (b_clr),
    .load     (1'b0),
    .load_val (8'h00),
    .shift    (b_shift),
    .digit    (key_code[3:0]),
    .value    (b_val)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_ENTER_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    a_clr      = 1'b0;
    a_load     = 1'b0;
    a_load_val = {4'h0, key_code[3:0]};
    a_shift    = 1'b0;
    b_clr      = 1'b0;
    b_shift    = 1'b0;
    op_load    = 1'b0;
    cap_exec   = 1'b0;
    cap_neg    = 1'b0;
    flags_clr  = 1'b0;
    ovf_clr    = 1'b0;
    rv_set     = 1'b0;

    case (state)
      ST_ENTER_A: begin
        if (accept && is_digit(key_code)) begin
          a_shift = 1'b1;
        end else if (accept && is_operator(key_code)) begin
          op_load   = 1'b1;
          b_clr     = 1'b1;
          state_nxt = ST_ENTER_B;
        end
      end
      ST_ENTER_B: begin
        if (accept && is_digit(key_code))         b_shift   = 1'b1;
        else if (accept && is_operator(key_code)) op_load   = 1'b1;
        else if (accept && key_code == KEY_EQ)    state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        cap_exec = 1'b1;
        // A subtract without carry-out borrowed: its result is a ten's complement.
        if (op_q == ALU_SUB && !alu_cout) begin
          state_nxt = ST_NEG;
        end else begin
          state_nxt = ST_SHOW;
          rv_set    = 1'b1;
        end
      end
      ST_NEG: begin
        cap_neg   = 1'b1;
        state_nxt = ST_SHOW;
        rv_set    = 1'b1;
      end
      ST_SHOW: begin
        if (accept && is_digit(key_code)) begin
          flags_clr = 1'b1;
          a_load    = 1'b1;
          state_nxt = ST_ENTER_A;
        end else if (accept && is_operator(key_code)) begin
`ifdef CALC_CHAIN_EN
          if (!neg) begin
            a_load     = 1'b1;
            a_load_val = result_q;
            op_load    = 1'b1;
            ovf_clr    = 1'b1;
            b_clr      = 1'b1;
            state_nxt  = ST_ENTER_B;
          end
`endif
        end
      end
      default: state_nxt = ST_ENTER_A;
    endcase

    if (accept && key_code == KEY_CLR) begin
      a_clr     = 1'b1;
      b_clr     = 1'b1;
      flags_clr = 1'b1;
      state_nxt = ST_ENTER_A;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      result_q     <= 8'h00;
      op_q         <= ALU_ADD;
      neg          <= 1'b0;
      ovf          <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= rv_set;
      if (op_load) op_q <= (key_code == KEY_SUB) ? ALU_SUB : ALU_ADD;
      if (flags_clr || ovf_clr) ovf <= 1'b0;
      if (flags_clr) neg <= 1'b0;
      if (cap_exec) begin
        result_q <= alu_result;
        neg      <= 1'b0;
        ovf      <= (op_q == ALU_ADD) && alu_cout;
      end
      if (cap_neg) begin
        result_q <= alu_result;
        neg      <= 1'b1;
      end
    end
  end

  // Second pass computes 0 - complement, which yields the magnitude.
  always_comb begin
    alu_op1    = 8'h00;
    alu_op2    = 8'h00;
    alu_opcode = ALU_ADD;
    if (state == ST_EXEC) begin
      alu_op1    = a_val;
      alu_op2    = b_val;
      alu_opcode = op_q;
    end else if (state == ST_NEG) begin
      alu_op2    = result_q;
      alu_opcode = ALU_SUB;
    end
  end

  always_comb begin
    case (state)
      ST_ENTER_A: display = a_val;
      ST_SHOW:    display = result_q;
      default:    display = b_val;
    endcase
  end

endmodule

// File: tb/tb_bcd_calc_ctrl.sv
// Self-checking bench for bcd_calc_ctrl with an arithmetic ALU model and a
// decimal reference model of the calculator.
module tb_bcd_calc_ctrl;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       key_valid = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic       key_ready, alu_cout, neg, ovf, result_valid, busy;
  logic [7:0] alu_op1, alu_op2, alu_result, display;
  logic [2:0] alu_opcode;

  int n_checks = 0;
  int n_fails = 0;

  int   m_a, m_b, m_res, m_mode;
  logic m_neg, m_ovf, m_sub;

  always #5 clk = ~clk;

  bcd_calc_ctrl dut (
    .clk          (clk),
    .nrst         (nrst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout),
    .display      (display),
    .neg          (neg),
    .ovf          (ovf),
    .result_valid (result_valid),
    .busy         (busy)
  );

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [8:0] alu_model(input logic [7:0] x, input logic [7:0] y,
                                           input logic [2:0] opc);
    int r;
    if (opc == ALU_SUB) begin
      r = from_bcd(x) - from_bcd(y);
      if (r >= 0) return {1'b1, to_bcd(r)};
      return {1'b0, to_bcd(r + 100)};
    end
    r = from_bcd(x) + from_bcd(y);
    return {(r > 99), to_bcd(r % 100)};
  endfunction

  assign {alu_cout, alu_result} = alu_model(alu_op1, alu_op2, alu_opcode);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_display();
    if (m_mode == 0) return m_a;
    if (m_mode == 1) return m_b;
    return m_res;
  endfunction

  task automatic reset_model();
    m_a = 0; m_b = 0; m_res = 0; m_mode = 0;
    m_neg = 1'b0; m_ovf = 1'b0; m_sub = 1'b0;
  endtask

  // Calculator behaviour for every key except an EQ that starts a calculation
  task automatic model_key(input logic [4:0] code);
    if (code <= 5'd9) begin
      if (m_mode == 0)      m_a = (m_a % 10) * 10 + int'(code);
      else if (m_mode == 1) m_b = (m_b % 10) * 10 + int'(code);
      else begin
        m_a = int'(code); m_neg = 1'b0; m_ovf = 1'b0; m_mode = 0;
      end
    end else if (code == KEY_ADD || code == KEY_SUB) begin
      if (m_mode == 0) begin
        m_sub = (code == KEY_SUB); m_b = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        m_sub = (code == KEY_SUB);
      end else begin
`ifdef CALC_CHAIN_EN
        if (!m_neg) begin
          m_a = m_res; m_sub = (code == KEY_SUB); m_ovf = 1'b0; m_b = 0; m_mode = 1;
        end
`endif
      end
    end else if (code == KEY_CLR) begin
      m_a = 0; m_b = 0; m_neg = 1'b0; m_ovf = 1'b0; m_mode = 0;
    end
  endtask

  task automatic check_view(input string tag);
    check({tag, ":display"}, 32'(display), 32'(to_bcd(exp_display())));
    check({tag, ":neg"}, 32'(neg), 32'(m_neg));
    check({tag, ":ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, ":key_ready"}, 32'(key_ready), 32'd1);
    check({tag, ":busy"}, 32'(busy), 32'd0);
    check({tag, ":alu_idle"}, {8'h0, alu_op1, alu_op2, 5'h0, alu_opcode}, 32'd0);
  endtask

  task automatic press(input logic [4:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    model_key(code);
  endtask

  task automatic do_eq(input logic inject, input logic [4:0] inj_code);
    int exp_res, exp_lat, cycles, busy_cycles;
    logic exp_neg, exp_ovf;
    if (!m_sub) begin
      exp_res = (m_a + m_b) % 100; exp_ovf = (m_a + m_b) > 99; exp_neg = 1'b0; exp_lat = 2;
    end else if (m_a >= m_b) begin
      exp_res = m_a - m_b; exp_ovf = 1'b0; exp_neg = 1'b0; exp_lat = 2;
    end else begin
      exp_res = m_b - m_a; exp_ovf = 1'b0; exp_neg = 1'b1; exp_lat = 3;
    end
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = KEY_EQ;
    @(negedge clk);
    key_valid = 1'b0;
    check("exec:busy", 32'(busy), 32'd1);
    check("exec:key_ready", 32'(key_ready), 32'd0);
    check("exec:result_valid", 32'(result_valid), 32'd0);
    check("exec:alu_ops", {16'h0, alu_op1, alu_op2}, {16'h0, to_bcd(m_a), to_bcd(m_b)});
    check("exec:opcode", 32'(alu_opcode), m_sub ? 32'(ALU_SUB) : 32'(ALU_ADD));
    if (inject) begin
      key_valid = 1'b1;
      key_code  = inj_code;
    end
    cycles = 1;
    busy_cycles = 1;
    while (result_valid !== 1'b1 && cycles < 8) begin
      @(negedge clk);
      key_valid = 1'b0;
      cycles++;
      if (busy === 1'b1) busy_cycles++;
      if (exp_lat == 3 && cycles == 2)
        check("neg:alu_ops", {13'h0, alu_op1, alu_op2, alu_opcode},
              {13'h0, 8'h00, to_bcd(100 - exp_res), ALU_SUB});
    end
    check("eq:latency", 32'(cycles), 32'(exp_lat));
    check("eq:busy_cycles", 32'(busy_cycles), 32'(exp_lat - 1));
    m_res = exp_res; m_neg = exp_neg; m_ovf = exp_ovf; m_mode = 2;
    check_view("show");
    @(negedge clk);
    check("show:rv_pulse", 32'(result_valid), 32'd0);
  endtask

  task automatic step(input logic [4:0] code);
    if (code == KEY_EQ && m_mode == 1) begin
      do_eq(1'b0, 5'd0);
    end else begin
      press(code);
      check_view("key");
    end
  endtask

  initial begin
    logic [4:0] rcode;
    reset_model();
    nrst = 1'b0;
    #12;
    check("rst:display", 32'(display), 32'h00);
    check("rst:flags", {28'h0, neg, ovf, result_valid, busy}, 32'd0);
    check("rst:key_ready", 32'(key_ready), 32'd1);
    check("rst:alu", {13'h0, alu_op1, alu_op2, alu_opcode}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // 45 + 38 = 83
    step(5'd4); step(5'd5); step(KEY_ADD); step(5'd3); step(5'd8); step(KEY_EQ);
    check("add83:display", 32'(display), 32'h83);
    // Operator after a result: chains into A, or is ignored
    step(KEY_SUB);
    step(5'd3);
    step(KEY_EQ);
`ifdef CALC_CHAIN_EN
    check("chain:display", 32'(display), 32'h80);
`endif
    step(KEY_CLR);

    // 72 - 15 = 57
    step(5'd7); step(5'd2); step(KEY_SUB); step(5'd1); step(5'd5); step(KEY_EQ);
    check("sub57:display", 32'(display), 32'h57);
    // 15 - 72 = -57
    step(KEY_CLR);
    step(5'd1); step(5'd5); step(KEY_SUB); step(5'd7); step(5'd2); step(KEY_EQ);
    check("subneg:neg", {23'h0, neg, display}, 32'h157);
    // 99 + 01 overflows to 00
    step(KEY_CLR);
    step(5'd9); step(5'd9); step(KEY_ADD); step(5'd0); step(5'd1); step(KEY_EQ);
    check("ovf:flags", {23'h0, ovf, display}, 32'h100);

    // Third digit shifts out the oldest; a key during EXEC is dropped
    step(KEY_CLR);
    step(5'd1); step(5'd2); step(5'd3);
    check("shift:display", 32'(display), 32'h23);
    step(KEY_ADD); step(5'd4);
    do_eq(1'b1, 5'd7);
    check("drop:display", 32'(display), 32'h27);
    step(KEY_CLR);
    check("clr:display", 32'(display), 32'h00);

    // Reset during EXEC aborts with no result pulse
    step(5'd5); step(KEY_ADD); step(5'd6);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = KEY_EQ;
    @(negedge clk);
    key_valid = 1'b0;
    check("abort:busy_before", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    check("abort:state", {22'h0, busy, key_ready, display}, {22'h0, 2'b01, 8'h00});
    reset_model();
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort:no_rv", 32'(result_valid), 32'd0);
    end
    check_view("abort");

    // Random key streams against the reference model
    for (int i = 0; i < 300; i++) begin
      rcode = 5'($urandom_range(0, 15));
      step(rcode);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
